// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver (sync, clock de-glitch, 11-bit deserializer)
// Ports: Clk/Reset_n (async active-low) system clock and reset; PS2Clk/PS2Data raw pad lines;
//        Enable 0 forces the receiver idle; RxData last good byte; RxValid good-byte strobe;
//        RxErr parity/stop/timeout strobe; Busy high while a frame is in progress.
// Define PS2_RX_TIMEOUT_EN to compile in the inter-edge watchdog (TIMEOUT_CYCLES).
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    input  logic       Enable,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       RxErr,
    output logic       Busy
);
    localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3;
    logic       clk_s1, clk_s2, dat_s1, dat_s2;
    logic       flt_clk, flt_d, fall;
    logic [7:0] flt_cnt;
    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       par;
    logic       tmo_hit;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            flt_clk <= 1'b1;
            flt_d   <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            clk_s1  <= PS2Clk;
            clk_s2  <= clk_s1;
            dat_s1  <= PS2Data;
            dat_s2  <= dat_s1;
            flt_d   <= flt_clk;
            fall    <= flt_d & ~flt_clk;
            // filtered clock only follows a level held for FILTER_LEN samples
            if (clk_s2 == flt_clk) flt_cnt <= '0;
            else if (flt_cnt == 8'(FILTER_LEN - 1)) begin
                flt_clk <= clk_s2;
                flt_cnt <= '0;
            end else flt_cnt <= flt_cnt + 8'd1;
        end
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            RxData  <= '0;
            RxValid <= 1'b0;
            RxErr   <= 1'b0;
        end else begin
            RxValid <= 1'b0;
            RxErr   <= 1'b0;
            if (!Enable) state <= S_IDLE;
            else if (fall) begin
                case (state)
                    S_IDLE: if (!dat_s2) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        state   <= (bit_cnt == 3'd7) ? S_PARITY : S_DATA;
                    end
                    S_PARITY: begin
                        par   <= dat_s2;
                        state <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                        // odd parity: data plus parity bit must hold an odd number of ones
                        if (dat_s2 && (^shift ^ par)) begin
                            RxData  <= shift;
                            RxValid <= 1'b1;
                        end else RxErr <= 1'b1;
                    end
                endcase
            end else if (tmo_hit) begin
                state <= S_IDLE;
                RxErr <= 1'b1;
            end
        end
    end
`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    // hit one count early so the error lands TIMEOUT_CYCLES+1 cycles after the fall flag
    assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) tmo_cnt <= '0;
        else tmo_cnt <= (!Enable || fall || state == S_IDLE || tmo_hit) ? '0 : tmo_cnt + TW'(1);
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif
    assign Busy = (state != S_IDLE);
endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

PS/2 device-to-host frame receiver placed directly upstream of the mouse controller's register/decoder logic. It synchronizes and de-glitches the raw PS2Clk/PS2Data lines and deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop). It presents each good byte to the controller as a one-cycle strobe and flags malformed or stalled frames.

## Interface
- FILTER_LEN, 8: consecutive Clk samples a new synchronized PS2Clk level must hold before the filtered clock changes (range 1-255).
- TIMEOUT_CYCLES, 10000: Clk cycles allowed between filtered falling edges inside a frame (200 µs at 50 MHz); counter width is $clog2(TIMEOUT_CYCLES+1).
- Clk  input  1  system clock, 50 MHz.
- Reset_n  input  1  asynchronous, active-low reset.
- PS2Clk  input  1  raw PS/2 clock line (pad input side).
- PS2Data  input  1  raw PS/2 data line (pad input side).
- Enable  input  1  1 = receive; 0 = host owns the bus, receiver forced idle.
- RxData  output  8  last good byte received.
- RxValid  output  1  one-cycle pulse, RxData updated this cycle.
- RxErr  output  1  one-cycle pulse on parity, stop or timeout error.
- Busy  output  1  high while the state machine is not IDLE.

## Operation
- Both raw lines pass through a 2-FF synchronizer; sync registers reset to 1.
- Clock filter: the filtered clock resets to 1. A counter increments while the synchronized clock differs from the filtered clock and clears when they match. At FILTER_LEN, the filtered clock takes the new value and the counter clears.
- Fall flag is registered: high for one cycle after the filtered clock goes 1→0. Data is sampled from the synchronized PS2Data in the same cycle the fall flag is high.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on the fall flag, except timeout and Enable.
  - IDLE: data=0 → DATA, bit counter=0. data=1 → stay in IDLE, no error.
  - DATA: shift right with sampled bit into [7]. After the 8th bit → PARITY.
  - PARITY: latch the sampled bit → STOP.
  - STOP: if stop bit=1 and XOR(shift, parity)=1, load RxData and pulse RxValid. Otherwise pulse RxErr and leave RxData unchanged. Both cases → IDLE.
- Timeout counter clears on every fall flag and whenever in IDLE. It counts in other states. Reaching TIMEOUT_CYCLES → IDLE and one RxErr pulse.
- Enable=0: FSM → IDLE next cycle and the timeout counter clears. No pulses are generated. Synchronizer and filter keep running.
- RxValid and RxErr are never high in the same cycle.
- Reset values: RxData=8'h00, RxValid=0, RxErr=0, Busy=0, FSM=IDLE.

## Timing
- Raw PS2Clk fall to filtered clock change: 2 + FILTER_LEN cycles, with the line held stable.
- Fall flag: 1 cycle after the filtered clock change.
- RxValid/RxErr register: 1 cycle after the fall flag. Total from the raw 11th fall: FILTER_LEN + 4 cycles.
- Busy rises 1 cycle after the fall flag of the start bit. It falls in the same cycle as RxValid/RxErr.
- Timeout error pulse: TIMEOUT_CYCLES + 1 cycles after the last fall flag.
- Reset_n assertion mid-frame: all state clears immediately. The partial frame is discarded with no pulse.
- A new start edge arriving in the cycle the FSM returns to IDLE is accepted.

## Configuration
- PS2_RX_TIMEOUT_EN defined: the timeout watchdog is compiled in as described.
- Not defined: no timeout counter and TIMEOUT_CYCLES is unused. A stalled frame holds the FSM until the next falling edges complete it, or until Enable=0 or Reset_n=0. RxErr then reports only parity and stop errors.

## Test plan
- Frame 0x5A, parity 1, stop 1, 80 µs bit period → one RxValid, RxData=0x5A, RxErr=0, pulse at FILTER_LEN+4 cycles after the 11th raw fall.
- Frame 0x08 with parity 1 (wrong) → one RxErr, no RxValid, RxData keeps its prior 0x5A. A following 0xFA frame (parity 1) → RxData=0xFA.
- PS2Clk low glitches of FILTER_LEN-1 cycles inserted in IDLE and mid-frame → no state change. A 0xFF frame still yields RxData=0xFF.
- With PS2_RX_TIMEOUT_EN: stop the clock after 5 data bits → RxErr exactly TIMEOUT_CYCLES+1 cycles after the last fall flag, Busy=0. The next 0x00 frame (parity 1) is received correctly.
- Drive Enable=0 after the 3rd bit for 1 ms, then restore → Busy=0 and no pulses during that time. The next full frame 0xFA is received correctly.
- Assert Reset_n=0 for 2 cycles mid-frame → RxData=0, Busy=0, no pulses. The remaining bits of the aborted frame produce no RxValid. The following frame is received.
